// File: rtl/pam4_pkg.sv
// Shared PAM4 types and symbol mapping, used by the serializer and by the
// downstream encoder/decoder stages.
package pam4_pkg;

    typedef logic [1:0] sym_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic sym_t bin2gray(input sym_t p);
        return p ^ (p >> 1);
    endfunction

endpackage

// File: rtl/pam4_serializer.sv
// Splits DATA_WIDTH-bit words into 2-bit PAM4 symbols with a valid/ready
// handshake on both sides; back-to-back words stream without a bubble.
module pam4_serializer
    import pam4_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit GRAY_EN    = 1'b0,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [1:0]            symbol_out,
    output logic                  symbol_out_valid,
    input  logic                  symbol_out_ready,
    output logic [15:0]           word_count
);

    localparam int NSYM  = DATA_WIDTH / 2;
    localparam int IDX_W = (NSYM > 1) ? $clog2(NSYM) : 1;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    sym_t                    sym_q, sym_d;
    logic                    vld_q, vld_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    consume;
    logic                    last;
    logic                    accept;

    function automatic sym_t map_pair(input sym_t p);
        return GRAY_EN ? bin2gray(p) : p;
    endfunction

    function automatic sym_t head_pair(input logic [DATA_WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[DATA_WIDTH-1 -: 2];
        end
        return w[1:0];
    endfunction

    // Remaining pairs are kept aligned so the next symbol is always at the head.
    function automatic logic [DATA_WIDTH-1:0] drop_pair(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? (w << 2) : (w >> 2);
    endfunction

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        sym_d   = sym_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;

        consume       = vld_q && symbol_out_ready;
        last          = consume && (idx_q == IDX_W'(NSYM - 1));
        data_in_ready = !rst && ((state_q == IDLE) || last);
        accept        = data_in_valid && data_in_ready;

        if (consume) begin
            if (last) begin
                state_d = IDLE;
                vld_d   = 1'b0;
                idx_d   = '0;
                cnt_d   = cnt_q + 16'd1;
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                sym_d   = map_pair(head_pair(shift_q));
                shift_d = drop_pair(shift_q);
            end
        end

        // A new word overrides the last-symbol retirement, giving the reload path.
        if (accept) begin
            state_d = SHIFT;
            vld_d   = 1'b1;
            idx_d   = '0;
            sym_d   = map_pair(head_pair(data_in));
            shift_d = drop_pair(data_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            sym_q   <= 2'b00;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sym_q   <= sym_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
        shift_q <= shift_d;
    end

    assign symbol_out       = sym_q;
    assign symbol_out_valid = vld_q;
    assign word_count       = cnt_q;

endmodule

// File: tb/tb_pam4_serializer.sv
// Directed bench for pam4_serializer: binary, Gray and LSB-first instances
// share stimulus; expected symbols are hand-derived per scenario.
module tb_pam4_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       symbol_out_ready = 1'b1;

    logic        rdy_b, rdy_g, rdy_l;
    logic [1:0]  sym_b, sym_g, sym_l;
    logic        vld_b, vld_g, vld_l;
    logic [15:0] wc_b, wc_g, wc_l;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pam4_serializer #(.DATA_WIDTH(8), .GRAY_EN(1'b0), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(rdy_b), .symbol_out(sym_b), .symbol_out_valid(vld_b),
        .symbol_out_ready(symbol_out_ready), .word_count(wc_b));

    pam4_serializer #(.DATA_WIDTH(8), .GRAY_EN(1'b1), .MSB_FIRST(1'b1)) u_gray (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(rdy_g), .symbol_out(sym_g), .symbol_out_valid(vld_g),
        .symbol_out_ready(symbol_out_ready), .word_count(wc_g));

    pam4_serializer #(.DATA_WIDTH(8), .GRAY_EN(1'b0), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
        .data_in_ready(rdy_l), .symbol_out(sym_l), .symbol_out_valid(vld_l),
        .symbol_out_ready(symbol_out_ready), .word_count(wc_l));

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", vld_b); end
        total++; if (sym_b !== 2'b00) begin bad++; $display("FAIL rst_symbol got=%b want=00", sym_b); end
        total++; if (wc_b !== 16'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", wc_b); end
        total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", rdy_b); end
        rst = 1'b0;
        #1;
        total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b want=1", rdy_b); end
    endtask

    // 0xB4 = 10 11 01 00
    task automatic test_single_word();
        logic [1:0] exp_b [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
        logic [1:0] exp_g [4] = '{2'b11, 2'b10, 2'b01, 2'b00};
        logic [1:0] exp_l [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
        @(negedge clk);
        data_in = 8'hB4;
        data_in_valid = 1'b1;
        #1;
        total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", rdy_b); end
        @(negedge clk);
        data_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (vld_b !== 1'b1) begin bad++; $display("FAIL single_valid[%0d] got=%b want=1", i, vld_b); end
            total++; if (sym_b !== exp_b[i]) begin bad++; $display("FAIL single_bin[%0d] got=%b want=%b", i, sym_b, exp_b[i]); end
            total++; if (sym_g !== exp_g[i]) begin bad++; $display("FAIL single_gray[%0d] got=%b want=%b", i, sym_g, exp_g[i]); end
            total++; if (sym_l !== exp_l[i]) begin bad++; $display("FAIL single_lsb[%0d] got=%b want=%b", i, sym_l, exp_l[i]); end
            @(negedge clk);
        end
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b want=0", vld_b); end
        total++; if (wc_b !== 16'd1) begin bad++; $display("FAIL single_count got=%0d want=1", wc_b); end
        total++; if (wc_g !== 16'd1) begin bad++; $display("FAIL single_count_gray got=%0d want=1", wc_g); end
        total++; if (wc_l !== 16'd1) begin bad++; $display("FAIL single_count_lsb got=%0d want=1", wc_l); end
    endtask

    // 0x1B = 00 01 10 11, 0xE4 = 11 10 01 00
    task automatic test_back_to_back();
        logic [1:0] exp_b [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00};
        logic [1:0] exp_l [8] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11};
        logic       exp_rdy;
        data_in = 8'h1B;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in = 8'hE4;
        for (int i = 0; i < 8; i++) begin
            exp_rdy = (i == 3) || (i == 7);
            total++; if (vld_b !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, vld_b); end
            total++; if (sym_b !== exp_b[i]) begin bad++; $display("FAIL b2b_bin[%0d] got=%b want=%b", i, sym_b, exp_b[i]); end
            total++; if (sym_l !== exp_l[i]) begin bad++; $display("FAIL b2b_lsb[%0d] got=%b want=%b", i, sym_l, exp_l[i]); end
            total++; if (rdy_b !== exp_rdy) begin bad++; $display("FAIL b2b_ready[%0d] got=%b want=%b", i, rdy_b, exp_rdy); end
            if (i == 4) data_in_valid = 1'b0;
            @(negedge clk);
        end
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL b2b_idle_valid got=%b want=0", vld_b); end
        total++; if (wc_b !== 16'd3) begin bad++; $display("FAIL b2b_count got=%0d want=3", wc_b); end
    endtask

    task automatic test_stall();
        data_in = 8'hB4;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        total++; if (sym_b !== 2'b10) begin bad++; $display("FAIL stall_sym0 got=%b want=10", sym_b); end
        @(negedge clk);
        total++; if (sym_b !== 2'b11) begin bad++; $display("FAIL stall_sym1 got=%b want=11", sym_b); end
        symbol_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (sym_b !== 2'b11) begin bad++; $display("FAIL stall_hold_sym[%0d] got=%b want=11", i, sym_b); end
            total++; if (vld_b !== 1'b1) begin bad++; $display("FAIL stall_hold_valid[%0d] got=%b want=1", i, vld_b); end
            total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL stall_hold_ready[%0d] got=%b want=0", i, rdy_b); end
        end
        symbol_out_ready = 1'b1;
        @(negedge clk);
        total++; if (sym_b !== 2'b01) begin bad++; $display("FAIL stall_sym2 got=%b want=01", sym_b); end
        @(negedge clk);
        total++; if (sym_b !== 2'b00) begin bad++; $display("FAIL stall_sym3 got=%b want=00", sym_b); end
        @(negedge clk);
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL stall_idle_valid got=%b want=0", vld_b); end
        total++; if (wc_b !== 16'd4) begin bad++; $display("FAIL stall_count got=%0d want=4", wc_b); end
    endtask

    task automatic test_reset_mid_word();
        data_in = 8'hB4;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        total++; if (sym_b !== 2'b10) begin bad++; $display("FAIL midrst_sym0 got=%b want=10", sym_b); end
        @(negedge clk);
        total++; if (sym_b !== 2'b11) begin bad++; $display("FAIL midrst_sym1 got=%b want=11", sym_b); end
        rst = 1'b1;
        @(negedge clk);
        total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", vld_b); end
        total++; if (wc_b !== 16'd0) begin bad++; $display("FAIL midrst_count got=%0d want=0", wc_b); end
        total++; if (sym_b !== 2'b00) begin bad++; $display("FAIL midrst_symbol got=%b want=00", sym_b); end
        total++; if (rdy_b !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b want=0", rdy_b); end
        rst = 1'b0;
        #1;
        total++; if (rdy_b !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got=%b want=1", rdy_b); end
        data_in = 8'h00;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (vld_b !== 1'b1) begin bad++; $display("FAIL midrst_new_valid[%0d] got=%b want=1", i, vld_b); end
            total++; if (sym_b !== 2'b00) begin bad++; $display("FAIL midrst_new_sym[%0d] got=%b want=00", i, sym_b); end
            @(negedge clk);
        end
        for (int i = 0; i < 3; i++) begin
            total++; if (vld_b !== 1'b0) begin bad++; $display("FAIL midrst_tail_valid[%0d] got=%b want=0", i, vld_b); end
            @(negedge clk);
        end
        total++; if (wc_b !== 16'd1) begin bad++; $display("FAIL midrst_count_after got=%0d want=1", wc_b); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_stall();
        test_reset_mid_word();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
